// File: rtl/id_stage_if.sv
// IF/ID-to-ID/EX bus for the decode stage: fetch-side inputs, writeback port,
// stall handshake back to fetch and the registered ID/EX fields.
interface id_stage_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] IF_pc_out;
    logic [31:0]     IF_instr_out;
    logic            InstrFlush;
    logic            wb_RegWrite;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            PC_write;
    logic            IFID_RegWrite;
    logic [XLEN-1:0] ID_pc;
    logic [XLEN-1:0] ID_rs1_data;
    logic [XLEN-1:0] ID_rs2_data;
    logic [XLEN-1:0] ID_imm;
    logic [4:0]      ID_rs1;
    logic [4:0]      ID_rs2;
    logic [4:0]      ID_rd;
    logic [2:0]      ID_funct3;
    logic            ID_funct7b5;
    logic [2:0]      ID_ALUOp;
    logic            ID_ALUSrc;
    logic            ID_MemRead;
    logic            ID_MemWrite;
    logic            ID_MemtoReg;
    logic            ID_RegWrite;
    logic [1:0]      ID_BranchType;

    modport master (
        output IF_pc_out, IF_instr_out, InstrFlush, wb_RegWrite, wb_rd, wb_data,
        input  PC_write, IFID_RegWrite, ID_pc, ID_rs1_data, ID_rs2_data, ID_imm,
               ID_rs1, ID_rs2, ID_rd, ID_funct3, ID_funct7b5, ID_ALUOp, ID_ALUSrc,
               ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_RegWrite, ID_BranchType
    );

    modport slave (
        input  IF_pc_out, IF_instr_out, InstrFlush, wb_RegWrite, wb_rd, wb_data,
        output PC_write, IFID_RegWrite, ID_pc, ID_rs1_data, ID_rs2_data, ID_imm,
               ID_rs1, ID_rs2, ID_rd, ID_funct3, ID_funct7b5, ID_ALUOp, ID_ALUSrc,
               ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_RegWrite, ID_BranchType
    );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: register file, immediate generation, load-use stall and ID/EX register.
// Optional macro REGFILE_BYPASS_EN makes same-cycle writeback visible to register reads.
module id_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input logic        clk,
    input logic        rst,
    id_stage_if.slave  bus
);

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_IALU   = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_R     = 3'd1,
        ALU_I     = 3'd2,
        ALU_BR    = 3'd3,
        ALU_LUI   = 3'd4,
        ALU_AUIPC = 3'd5,
        ALU_JUMP  = 3'd6
    } aluop_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_COND = 2'd1,
        BR_JAL  = 2'd2,
        BR_JALR = 2'd3
    } branch_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            funct7b5;
        aluop_e          alu_op;
        logic            alu_src;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            reg_write;
        branch_e         branch_type;
    } idex_t;

    logic [31:0]     instr;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rf [NREG];
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            hazard;
    idex_t           dec;
    idex_t           idex;

    assign instr = bus.IF_instr_out;
    assign rs1   = instr[19:15];
    assign rs2   = instr[24:20];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (bus.wb_RegWrite && bus.wb_rd != '0) begin
            rf[bus.wb_rd] <= bus.wb_data;
        end
    end

    always_comb begin
        rs1_data = (rs1 == '0) ? '0 : rf[rs1];
        rs2_data = (rs2 == '0) ? '0 : rf[rs2];
`ifdef REGFILE_BYPASS_EN
        if (bus.wb_RegWrite && bus.wb_rd != '0 && bus.wb_rd == rs1) rs1_data = bus.wb_data;
        if (bus.wb_RegWrite && bus.wb_rd != '0 && bus.wb_rd == rs2) rs2_data = bus.wb_data;
`endif
    end

    assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
    assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec          = '0;
        dec.pc       = bus.IF_pc_out;
        dec.rs1_data = rs1_data;
        dec.rs2_data = rs2_data;
        dec.rs1      = rs1;
        dec.rs2      = rs2;
        dec.rd       = instr[11:7];
        dec.funct3   = instr[14:12];
        dec.funct7b5 = instr[30];
        uses_rs1     = 1'b0;
        uses_rs2     = 1'b0;
        case (instr[6:0])
            OP_R: begin
                dec.alu_op = ALU_R; dec.reg_write = 1'b1;
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            OP_IALU: begin
                dec.alu_op = ALU_I; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                dec.imm = imm_i; uses_rs1 = 1'b1;
            end
            OP_LOAD: begin
                dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.mem_read = 1'b1;
                dec.mem_to_reg = 1'b1; dec.reg_write = 1'b1;
                dec.imm = imm_i; uses_rs1 = 1'b1;
            end
            OP_STORE: begin
                dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.mem_write = 1'b1;
                dec.imm = imm_s; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                dec.alu_op = ALU_BR; dec.branch_type = BR_COND;
                dec.imm = imm_b; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            OP_LUI: begin
                dec.alu_op = ALU_LUI; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                dec.imm = imm_u;
            end
            OP_AUIPC: begin
                dec.alu_op = ALU_AUIPC; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                dec.imm = imm_u;
            end
            OP_JAL: begin
                dec.alu_op = ALU_JUMP; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                dec.branch_type = BR_JAL; dec.imm = imm_j;
            end
            OP_JALR: begin
                dec.alu_op = ALU_JUMP; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                dec.branch_type = BR_JALR; dec.imm = imm_i; uses_rs1 = 1'b1;
            end
            default: begin
                // Unsupported opcodes become a NOP: control bits stay 0, no trap.
            end
        endcase
    end

    // The inserted bubble clears ID_MemRead, so a load-use stall lasts one cycle.
    assign hazard = idex.mem_read && idex.rd != '0 &&
                    ((uses_rs1 && idex.rd == rs1) || (uses_rs2 && idex.rd == rs2));

    assign bus.PC_write      = bus.InstrFlush || !hazard;
    assign bus.IFID_RegWrite = bus.InstrFlush || !hazard;

    always_ff @(posedge clk) begin
        if (rst || bus.InstrFlush || hazard) begin
            idex <= '0;
        end else begin
            idex <= dec;
        end
    end

    assign bus.ID_pc         = idex.pc;
    assign bus.ID_rs1_data   = idex.rs1_data;
    assign bus.ID_rs2_data   = idex.rs2_data;
    assign bus.ID_imm        = idex.imm;
    assign bus.ID_rs1        = idex.rs1;
    assign bus.ID_rs2        = idex.rs2;
    assign bus.ID_rd         = idex.rd;
    assign bus.ID_funct3     = idex.funct3;
    assign bus.ID_funct7b5   = idex.funct7b5;
    assign bus.ID_ALUOp      = idex.alu_op;
    assign bus.ID_ALUSrc     = idex.alu_src;
    assign bus.ID_MemRead    = idex.mem_read;
    assign bus.ID_MemWrite   = idex.mem_write;
    assign bus.ID_MemtoReg   = idex.mem_to_reg;
    assign bus.ID_RegWrite   = idex.reg_write;
    assign bus.ID_BranchType = idex.branch_type;

endmodule

// File: tb/tb_id_stage.sv
// Directed scoreboard bench for id_stage: decode, immediates, load-use stall, flush,
// register-file write rules and reset-during-stall.
module tb_id_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_stage_if #(.XLEN(32)) bus();
    id_stage #(.XLEN(32), .NREG(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        string       tag;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic        f7;
        logic [2:0]  aluop;
        logic        alusrc, mr, mw, m2r, rw;
        logic [1:0]  bt;
    } exp_t;

    exp_t        sbq[$];
    int unsigned total = 0;
    int unsigned bad   = 0;

    localparam logic [31:0] I_ADD_X5  = 32'h005281B3; // add  x3,x5,x5
    localparam logic [31:0] I_ADDI    = 32'hFFB00093; // addi x1,x0,-5
    localparam logic [31:0] I_LW      = 32'h0000A103; // lw   x2,0(x1)
    localparam logic [31:0] I_ADD_X2  = 32'h002101B3; // add  x3,x2,x2
    localparam logic [31:0] I_ADDI_X7 = 32'h00138213; // addi x4,x7,1
    localparam logic [31:0] I_SW      = 32'hFE20AC23; // sw   x2,-8(x1)
    localparam logic [31:0] I_BEQ     = 32'hFE000EE3; // beq  x0,x0,-4
    localparam logic [31:0] I_JAL     = 32'h0010006F; // jal  x0,+2048
    localparam logic [31:0] I_BAD     = 32'h0000007F;

`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] RAW_X7 = 32'h00001234;
`else
    localparam logic [31:0] RAW_X7 = 32'h00000055;
`endif

    function automatic exp_t mk(input string tag,
                                input logic [31:0] pc, rs1d, rs2d, imm,
                                input logic [4:0] rs1, rs2, rd,
                                input logic [2:0] f3, input logic f7,
                                input logic [2:0] aluop,
                                input logic alusrc, mr, mw, m2r, rw,
                                input logic [1:0] bt);
        exp_t e;
        e.tag = tag; e.pc = pc; e.rs1d = rs1d; e.rs2d = rs2d; e.imm = imm;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.f3 = f3; e.f7 = f7;
        e.aluop = aluop; e.alusrc = alusrc; e.mr = mr; e.mw = mw; e.m2r = m2r;
        e.rw = rw; e.bt = bt;
        return e;
    endfunction

    function automatic exp_t bubble(input string tag);
        return mk(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic compare(input exp_t e);
        chk({e.tag, ".pc"},      bus.ID_pc,               e.pc);
        chk({e.tag, ".rs1d"},    bus.ID_rs1_data,         e.rs1d);
        chk({e.tag, ".rs2d"},    bus.ID_rs2_data,         e.rs2d);
        chk({e.tag, ".imm"},     bus.ID_imm,              e.imm);
        chk({e.tag, ".rs1"},     32'(bus.ID_rs1),         32'(e.rs1));
        chk({e.tag, ".rs2"},     32'(bus.ID_rs2),         32'(e.rs2));
        chk({e.tag, ".rd"},      32'(bus.ID_rd),          32'(e.rd));
        chk({e.tag, ".funct3"},  32'(bus.ID_funct3),      32'(e.f3));
        chk({e.tag, ".f7b5"},    32'(bus.ID_funct7b5),    32'(e.f7));
        chk({e.tag, ".aluop"},   32'(bus.ID_ALUOp),       32'(e.aluop));
        chk({e.tag, ".alusrc"},  32'(bus.ID_ALUSrc),      32'(e.alusrc));
        chk({e.tag, ".memrd"},   32'(bus.ID_MemRead),     32'(e.mr));
        chk({e.tag, ".memwr"},   32'(bus.ID_MemWrite),    32'(e.mw));
        chk({e.tag, ".m2r"},     32'(bus.ID_MemtoReg),    32'(e.m2r));
        chk({e.tag, ".regwr"},   32'(bus.ID_RegWrite),    32'(e.rw));
        chk({e.tag, ".brtype"},  32'(bus.ID_BranchType),  32'(e.bt));
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic flush);
        bus.IF_pc_out    = pc;
        bus.IF_instr_out = instr;
        bus.InstrFlush   = flush;
    endtask

    task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] d);
        bus.wb_RegWrite = en;
        bus.wb_rd       = rd;
        bus.wb_data     = d;
    endtask

    task automatic chk_stall(input string tag, input logic go);
        #1;
        chk({tag, ".PC_write"},      32'(bus.PC_write),      32'(go));
        chk({tag, ".IFID_RegWrite"}, 32'(bus.IFID_RegWrite), 32'(go));
    endtask

    // One ID/EX capture: pop the oldest expectation once the edge has produced output.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        total++;
        assert (sbq.size() != 0) else begin
            bad++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            compare(e);
        end
    endtask

    initial begin
        drive(32'h0, 32'h0, 1'b0);
        wb(1'b0, 5'd0, 32'h0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compare(bubble("reset"));
        rst = 1'b0;
        chk_stall("after_reset", 1'b1);

        drive(32'h0C, I_ADD_X5, 1'b0);
        sbq.push_back(mk("add_x5", 32'h0C, 0, 0, 0, 5, 5, 3, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        tick();

        drive(32'h0, 32'h0, 1'b0);
        wb(1'b1, 5'd1, 32'h100);
        sbq.push_back(bubble("nop0"));
        tick();
        wb(1'b1, 5'd2, 32'h22);
        sbq.push_back(bubble("nop1"));
        tick();
        wb(1'b1, 5'd7, 32'h55);
        sbq.push_back(bubble("nop2"));
        tick();

        drive(32'h10, I_ADDI, 1'b0);
        wb(1'b1, 5'd0, 32'hDEAD);
        sbq.push_back(mk("addi", 32'h10, 0, 0, 32'hFFFFFFFB, 0, 27, 1, 0, 1, 2, 1, 0, 0, 0, 1, 0));
        tick();
        wb(1'b0, 5'd0, 32'h0);

        drive(32'h20, I_LW, 1'b0);
        sbq.push_back(mk("lw", 32'h20, 32'h100, 0, 0, 1, 0, 2, 2, 0, 0, 1, 1, 0, 1, 1, 0));
        chk_stall("lw", 1'b1);
        tick();

        drive(32'h24, I_ADD_X2, 1'b0);
        sbq.push_back(bubble("stall_bubble"));
        chk_stall("loaduse", 1'b0);
        tick();
        sbq.push_back(mk("add_issue", 32'h24, 32'h22, 32'h22, 0, 2, 2, 3, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        chk_stall("stall_over", 1'b1);
        tick();

        drive(32'h30, I_LW, 1'b0);
        sbq.push_back(mk("lw2", 32'h30, 32'h100, 0, 0, 1, 0, 2, 2, 0, 0, 1, 1, 0, 1, 1, 0));
        tick();
        drive(32'h34, I_ADD_X2, 1'b1);
        sbq.push_back(bubble("flush_bubble"));
        chk_stall("flush_hazard", 1'b1);
        tick();
        drive(32'h40, I_ADD_X2, 1'b0);
        sbq.push_back(mk("after_flush", 32'h40, 32'h22, 32'h22, 0, 2, 2, 3, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        chk_stall("after_flush", 1'b1);
        tick();

        drive(32'h44, I_ADDI_X7, 1'b0);
        wb(1'b1, 5'd7, 32'h1234);
        sbq.push_back(mk("raw", 32'h44, RAW_X7, 32'h100, 1, 7, 1, 4, 0, 0, 2, 1, 0, 0, 0, 1, 0));
        tick();
        wb(1'b0, 5'd0, 32'h0);
        drive(32'h48, I_ADDI_X7, 1'b0);
        sbq.push_back(mk("raw_after", 32'h48, 32'h1234, 32'h100, 1, 7, 1, 4, 0, 0, 2, 1, 0, 0, 0, 1, 0));
        tick();

        drive(32'h4C, I_SW, 1'b0);
        sbq.push_back(mk("sw", 32'h4C, 32'h100, 32'h22, 32'hFFFFFFF8, 1, 2, 24, 2, 1, 0, 1, 0, 1, 0, 0, 0));
        tick();
        drive(32'h50, I_BEQ, 1'b0);
        sbq.push_back(mk("beq", 32'h50, 0, 0, 32'hFFFFFFFC, 0, 0, 29, 0, 1, 3, 0, 0, 0, 0, 0, 1));
        tick();
        drive(32'h54, I_JAL, 1'b0);
        sbq.push_back(mk("jal", 32'h54, 0, 32'h100, 32'h800, 0, 1, 0, 0, 0, 6, 1, 0, 0, 0, 1, 2));
        tick();
        drive(32'h58, I_BAD, 1'b0);
        sbq.push_back(mk("unknown", 32'h58, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();

        drive(32'h60, I_LW, 1'b0);
        sbq.push_back(mk("lw3", 32'h60, 32'h100, 0, 0, 1, 0, 2, 2, 0, 0, 1, 1, 0, 1, 1, 0));
        tick();
        drive(32'h64, I_ADD_X2, 1'b0);
        chk_stall("pre_reset_stall", 1'b0);
        rst = 1'b1;
        sbq.push_back(bubble("reset_mid_stall"));
        tick();
        rst = 1'b0;
        chk_stall("post_reset", 1'b1);
        sbq.push_back(mk("rf_cleared", 32'h64, 0, 0, 0, 2, 2, 3, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        tick();

        total++;
        assert (sbq.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sbq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Instruction-decode stage of the 5-stage RV32I pipeline. It sits directly downstream of the fetch stage and consumes the IF/ID register outputs (IF_pc_out, IF_instr_out).
- Decodes the instruction, reads the 32x32 register file and generates the immediate.
- Detects load-use hazards and drives PC_write / IFID_RegWrite back to fetch.
- Registers all results into the ID/EX pipeline register.

Parameters:
XLEN, 32, datapath width
NREG, 32, number of architectural registers (x0 hardwired 0)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous reset, active-high; sampled on posedge clk
IF_pc_out  in  32  PC of instruction in IF/ID
IF_instr_out  in  32  instruction in IF/ID (0 = flushed bubble)
InstrFlush  in  1  taken branch/jump resolved in EX; kill instruction entering ID/EX
wb_RegWrite  in  1  writeback enable
wb_rd  in  5  writeback destination
wb_data  in  32  writeback data
PC_write  out  1  0 = hold PC (stall)
IFID_RegWrite  out  1  0 = hold IF/ID register (stall)
ID_pc  out  32  registered PC
ID_rs1_data, ID_rs2_data  out  32 each  registered operands
ID_imm  out  32  registered sign-extended immediate
ID_rs1, ID_rs2, ID_rd  out  5 each  registered register indices
ID_funct3  out  3  registered funct3
ID_funct7b5  out  1  registered instr[30]
ID_ALUOp  out  3  0 add, 1 R-type, 2 I-ALU, 3 branch, 4 LUI, 5 AUIPC, 6 JAL/JALR
ID_ALUSrc  out  1  1 = immediate operand
ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_RegWrite  out  1 each  registered controls
ID_BranchType  out  2  0 none, 1 cond branch, 2 JAL, 3 JALR

Behaviour:
- Reset (rst=1 at posedge):
  - All ID_* outputs are 0.
  - All register file entries are 0.
  - PC_write=1 and IFID_RegWrite=1 from the first cycle after reset.
- Register file:
  - Combinational read, write at posedge when wb_RegWrite && wb_rd!=0.
  - Reads of x0 return 0.
  - Writes to x0 are ignored.
- Immediates (all sign-extended from instr[31]):
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Opcode decode:
  - Supported: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
  - Any other opcode, including 0, decodes to a NOP: all controls 0. There is no trap.
- uses_rs1 is 0 for LUI, AUIPC and JAL. uses_rs2 is 1 only for R, STORE and BRANCH.
- Load-use hazard (combinational): hazard = ID_MemRead && ID_rd!=0 && ((uses_rs1 && ID_rd==rs1) || (uses_rs2 && ID_rd==rs2)).
  - On hazard: PC_write=0 and IFID_RegWrite=0.
  - At the next posedge ID/EX loads a bubble (all control bits 0, data fields don't-care but driven 0).
  - Stall length is exactly 1 cycle.
- Flush: InstrFlush=1 at posedge makes ID/EX load a bubble.
  - Flush has priority over hazard: PC_write=1 and IFID_RegWrite=1 whenever InstrFlush=1.
- Otherwise ID/EX loads the decoded fields every cycle. Latency is 1 cycle IF/ID→ID/EX.
- rst asserted mid-stall or mid-flush: reset wins, and the stall state is discarded.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: when wb_RegWrite && wb_rd!=0 && wb_rd==rsN in the same cycle, the read of rsN returns wb_data (write-through).
- Not defined: the read returns the old register value. Writeback-to-decode forwarding is then the EX forwarding unit's responsibility.

Test Plan:
- Reset: rst=1 for 2 cycles → all ID_* = 0, PC_write=1, IFID_RegWrite=1. Reading x5 returns 0.
- Decode ADDI x1,x0,-5 (0xFFB00093) at PC 0x10 → next cycle ID_pc=0x10, ID_imm=0xFFFFFFFB, ID_rd=1, ID_ALUOp=2, ID_ALUSrc=1, ID_RegWrite=1.
- Load-use: LW x2,0(x1) then ADD x3,x2,x2 → while ADD is in ID: PC_write=0 and IFID_RegWrite=0 for exactly 1 cycle; ID/EX holds a bubble (ID_RegWrite=0); ADD issues the following cycle.
- Flush during hazard: same as the load-use case with InstrFlush=1 → PC_write=1, ID/EX bubble, no stall cycle.
- Write x0 / same-cycle RAW: wb_rd=0 with wb_data=0xDEAD → x0 still reads 0. wb_rd=7 with wb_data=0x1234 while decoding rs1=7 → ID_rs1_data=0x1234 with REGFILE_BYPASS_EN, old value without it.
- Immediate formats:
  - BEQ with offset -4 (0xFE000EE3) → ID_imm=0xFFFFFFFC, ID_BranchType=1.
  - JAL with offset +2048 (0x0010006F) → ID_imm=0x00000800, ID_BranchType=2.
  - Unknown opcode 0x0000007F → all controls 0.
